// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and defaults for the memory access controller
//
// Contents:
//   state_t          sequencer states
//   OP_READ/OP_WRITE encoding of req_write
//   DEF_*            default widths for the 32x32 word memory
package mem_ctrl_pkg;

    localparam int DEF_ADDR_LEN  = 5;
    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_LEN_W     = 2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WACK = 3'd2,
        RD   = 3'd3,
        RRSP = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - request sequencer in front of the single-port word memory
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (req_ready = idle)
//   req_write, req_addr, req_wdata   request opcode, start address, write data
//   req_len                          read burst beats minus one
//   rsp_valid/rsp_ready              response handshake
//   rsp_write, rsp_rdata, rsp_last   write-ack flag, read data, final beat
//   mem_addr, mem_r_en, mem_w_en     registered memory controls
//   mem_data_in, mem_data_out        memory write data / combinational read data
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_LEN  = DEF_ADDR_LEN,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_LEN-1:0]  req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    input  logic [LEN_W-1:0]     req_len,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_last,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic                 mem_r_en,
    output logic                 mem_w_en,
    output logic [WORD_SIZE-1:0] mem_data_in,
    input  logic [WORD_SIZE-1:0] mem_data_out
);

    localparam logic [ADDR_LEN-1:0] ADDR_ONE = {{(ADDR_LEN-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]    LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     beats_left_q, beats_left_d;
    // mem_addr_q doubles as the current burst address and mem_data_in_q as
    // the latched write data; they only move when a strobe is being raised.
    logic [ADDR_LEN-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_data_in_q, mem_data_in_d;
    logic                 mem_r_en_q, mem_r_en_d;
    logic                 mem_w_en_q, mem_w_en_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_write_q, rsp_write_d;
    logic [WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_last_q, rsp_last_d;

    always_comb begin
        state_d       = state_q;
        beats_left_d  = beats_left_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        // Strobes default low so each one is a single-cycle pulse per beat.
        mem_r_en_d    = 1'b0;
        mem_w_en_d    = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_last_d    = rsp_last_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_d   = req_addr;
                    beats_left_d = req_len;
                    if (req_write == OP_WRITE) begin
                        mem_data_in_d = req_wdata;
                        mem_w_en_d    = 1'b1;
                        state_d       = WR;
                    end else begin
                        mem_r_en_d = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            WR: begin
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b1;
                rsp_last_d  = 1'b1;
                rsp_rdata_d = '0;
                state_d     = WACK;
            end
            WACK: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_write_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            RD: begin
                // The memory read is combinational; capture it as r_en closes.
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b0;
                rsp_rdata_d = mem_data_out;
                rsp_last_d  = (beats_left_q == '0);
                state_d     = RRSP;
            end
            RRSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (beats_left_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        // Address wraps naturally at 2^ADDR_LEN.
                        mem_addr_d   = mem_addr_q + ADDR_ONE;
                        beats_left_d = beats_left_q - LEN_ONE;
                        mem_r_en_d   = 1'b1;
                        state_d      = RD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beats_left_q  <= '0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_r_en_q    <= 1'b0;
            mem_w_en_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            beats_left_q  <= beats_left_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_r_en_q    <= mem_r_en_d;
            mem_w_en_q    <= mem_w_en_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_last_q    <= rsp_last_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_last    = rsp_last_q;
    assign mem_addr    = mem_addr_q;
    assign mem_r_en    = mem_r_en_q;
    assign mem_w_en    = mem_w_en_q;
    assign mem_data_in = mem_data_in_q;

endmodule
